// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave, one grant at a time, with a stalled-strobe bus-error timeout.
// Grant registers one cycle after request; request/response paths are combinational; a master waits until its grant appears.
module wb_rr_arbiter #(
  parameter int NM      = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SW      = DW / 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,

  input  logic [NM-1:0]        i_mcyc,
  input  logic [NM-1:0]        i_mstb,
  input  logic [NM-1:0]        i_mwe,
  input  logic [NM*AW-1:0]     i_maddr,
  input  logic [NM*DW-1:0]     i_mdata,
  input  logic [NM*SW-1:0]     i_msel,

  output logic [NM-1:0]        o_mack,
  output logic [NM-1:0]        o_merr,
  output logic [NM*DW-1:0]     o_mdata,

  output logic                 o_scyc,
  output logic                 o_sstb,
  output logic                 o_swe,
  output logic [AW-1:0]        o_saddr,
  output logic [DW-1:0]        o_sdata,
  output logic [SW-1:0]        o_ssel,

  input  logic                 i_sack,
  input  logic                 i_serr,
  input  logic [DW-1:0]        i_sdata,

  output logic [NM-1:0]        o_grant
);

  localparam int IW = $clog2(NM);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  logic [NM-1:0]   grant;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   tcnt;

  logic            found_hi;
  logic            found_lo;
  logic [IW-1:0]   idx_hi;
  logic [IW-1:0]   idx_lo;
  logic [IW-1:0]   arb_idx;
  logic            arb_found;
  logic            gcyc;
  logic            stall;
  logic            to_err;

  // Rotating priority: first requester at or above ptr, else wrap to the lowest requester.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int k = 0; k < NM; k++) begin
      if (!found_hi && i_mcyc[k] && (IW'(k) >= ptr)) begin
        found_hi = 1'b1;
        idx_hi   = IW'(k);
      end
      if (!found_lo && i_mcyc[k]) begin
        found_lo = 1'b1;
        idx_lo   = IW'(k);
      end
    end
    arb_found = found_lo;
    arb_idx   = found_hi ? idx_hi : idx_lo;
  end

  assign gcyc = |(i_mcyc & grant);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      ptr   <= '0;
    end else if (state == IDLE) begin
      if (arb_found) begin
        state <= BUSY;
        gidx  <= arb_idx;
        grant <= {{(NM-1){1'b0}}, 1'b1} << arb_idx;
      end
    end else begin
      // Release always passes through IDLE, so a new grant never lands back-to-back.
      if (!gcyc) begin
        state <= IDLE;
        grant <= '0;
        ptr   <= (gidx == IW'(NM - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end

  // grant is all-zero outside BUSY, so the slave side idles at zero.
  always_comb begin
    o_scyc  = 1'b0;
    o_sstb  = 1'b0;
    o_swe   = 1'b0;
    o_saddr = '0;
    o_sdata = '0;
    o_ssel  = '0;
    for (int k = 0; k < NM; k++) begin
      if (grant[k]) begin
        o_scyc  = i_mcyc[k];
        o_sstb  = i_mstb[k];
        o_swe   = i_mwe[k];
        o_saddr = i_maddr[k*AW +: AW];
        o_sdata = i_mdata[k*DW +: DW];
        o_ssel  = i_msel[k*SW +: SW];
      end
    end
  end

  // A slave ack or error in the same cycle wins over the timeout.
  assign stall  = o_sstb & ~i_sack & ~i_serr;
  assign to_err = stall && (tcnt == CW'(TIMEOUT));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tcnt <= '0;
    end else if (!stall || to_err) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_comb begin
    o_mack  = grant & {NM{i_sack}};
    o_merr  = grant & {NM{i_serr | to_err}};
    o_mdata = '0;
    for (int k = 0; k < NM; k++) begin
      if (grant[k]) begin
        o_mdata[k*DW +: DW] = i_sdata;
      end
    end
  end

  assign o_grant = grant;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: vector table for arbitration/routing, hand sequences for timeout and async reset.
module tb_wb_rr_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;
  localparam logic [31:0] SDATA = 32'hCAFE_F00D;
  localparam logic [3:0]  WE    = 4'b0101;

  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic [NM-1:0]     i_mcyc, i_mstb, i_mwe;
  logic [NM*AW-1:0]  i_maddr;
  logic [NM*DW-1:0]  i_mdata;
  logic [NM*SW-1:0]  i_msel;
  logic [NM-1:0]     o_mack, o_merr;
  logic [NM*DW-1:0]  o_mdata;
  logic              o_scyc, o_sstb, o_swe;
  logic [AW-1:0]     o_saddr;
  logic [DW-1:0]     o_sdata;
  logic [SW-1:0]     o_ssel;
  logic              i_sack, i_serr;
  logic [DW-1:0]     i_sdata;
  logic [NM-1:0]     o_grant;

  wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_mcyc(i_mcyc), .i_mstb(i_mstb), .i_mwe(i_mwe),
    .i_maddr(i_maddr), .i_mdata(i_mdata), .i_msel(i_msel),
    .o_mack(o_mack), .o_merr(o_merr), .o_mdata(o_mdata),
    .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe),
    .o_saddr(o_saddr), .o_sdata(o_sdata), .o_ssel(o_ssel),
    .i_sack(i_sack), .i_serr(i_serr), .i_sdata(i_sdata),
    .o_grant(o_grant)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0] addr_tab [4];
  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] cyc;
    logic       sack;
    logic       serr;
    logic [3:0] grant;
    logic       scyc;
    logic [3:0] mack;
    logic [3:0] merr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] cyc, input logic sack, input logic serr,
                              input logic [3:0] g, input logic scyc,
                              input logic [3:0] mack, input logic [3:0] merr);
    vec_t v;
    v.cyc = cyc; v.sack = sack; v.serr = serr;
    v.grant = g; v.scyc = scyc; v.mack = mack; v.merr = merr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] cyc, input logic sack, input logic serr);
    i_mcyc = cyc;
    i_mstb = cyc;
    i_mwe  = cyc & WE;
    i_sack = sack;
    i_serr = serr;
  endtask

  task automatic check_bus(input string tag, input logic [3:0] g, input logic scyc,
                           input logic sstb, input logic swe,
                           input logic [3:0] mack, input logic [3:0] merr);
    int gi;
    logic [31:0]  e_addr, e_wdat;
    logic [3:0]   e_sel;
    logic [127:0] e_mdata;
    gi = -1;
    e_mdata = '0;
    for (int k = 0; k < NM; k++) begin
      if (g[k]) begin
        gi = k;
        e_mdata[k*32 +: 32] = SDATA;
      end
    end
    e_addr = (gi >= 0) ? addr_tab[gi] : 32'h0;
    e_wdat = (gi >= 0) ? 32'hD000_0000 + 32'(gi) : 32'h0;
    e_sel  = (gi >= 0) ? (4'b0001 << gi) : 4'b0000;
    chk({tag, "_grant"}, 128'(o_grant), 128'(g));
    chk({tag, "_scyc"},  128'(o_scyc),  128'(scyc));
    chk({tag, "_sstb"},  128'(o_sstb),  128'(sstb));
    chk({tag, "_swe"},   128'(o_swe),   128'(swe));
    chk({tag, "_saddr"}, 128'(o_saddr), 128'(e_addr));
    chk({tag, "_sdata"}, 128'(o_sdata), 128'(e_wdat));
    chk({tag, "_ssel"},  128'(o_ssel),  128'(e_sel));
    chk({tag, "_mack"},  128'(o_mack),  128'(mack));
    chk({tag, "_merr"},  128'(o_merr),  128'(merr));
    chk({tag, "_mdata"}, 128'(o_mdata), e_mdata);
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t v;
    addr_tab[0] = 32'h1200; addr_tab[1] = 32'h1300;
    addr_tab[2] = 32'h1000; addr_tab[3] = 32'h1100;
    for (int k = 0; k < NM; k++) begin
      i_maddr[k*32 +: 32] = addr_tab[k];
      i_mdata[k*32 +: 32] = 32'hD000_0000 + 32'(k);
      i_msel[k*4 +: 4]    = 4'b0001 << k;
    end
    i_sdata   = SDATA;
    i_reset_n = 1'b1;
    drive(4'b0000, 1'b0, 1'b0);

    // Fairness from ptr=0: each master drops after one ack, others keep requesting.
    vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b1110, 1'b0, 1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 4'b0010, 4'b0000));
    vecs.push_back(mk(4'b1101, 1'b0, 1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b1011, 1'b0, 1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b1000, 4'b0000));
    vecs.push_back(mk(4'b0111, 1'b0, 1'b0, 4'b1000, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000));
    // Single request from master 2 (ptr=1), one wait state then ack.
    vecs.push_back(mk(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000));
    // Slave error routed to master 3 (ptr=3); idle ack/err reach nobody.
    vecs.push_back(mk(4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b1000, 1'b0, 1'b1, 4'b1000, 1'b1, 4'b0000, 4'b1000));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 4'b1000, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000));
    // Master 0 releases as master 3 raises cyc (ptr=0).
    vecs.push_back(mk(4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000));
    vecs.push_back(mk(4'b1000, 1'b0, 1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 4'b1000, 4'b0000));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 4'b1000, 1'b0, 4'b0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000));

    // Reset with every master requesting and the slave responding: all outputs stay zero.
    #1;
    i_reset_n = 1'b0;
    drive(4'b1111, 1'b1, 1'b1);
    #2;
    check_bus("rst_a", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    @(posedge i_clk);
    next_cycle();
    check_bus("rst_b", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    i_reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.cyc, v.sack, v.serr);
      #2;
      check_bus($sformatf("v%0d", i), v.grant, v.scyc, v.scyc,
                |(v.grant & v.cyc & WE), v.mack, v.merr);
      next_cycle();
    end

    // Timeout: master 1 stalls; error on stalled cycles 5 and 10, ack wins on cycle 15.
    drive(4'b0010, 1'b0, 1'b0);
    #2;
    check_bus("to0", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    next_cycle();
    for (int n = 1; n <= 16; n++) begin
      drive(4'b0010, (n == 15), 1'b0);
      #2;
      check_bus($sformatf("to%0d", n), 4'b0010, 1'b1, 1'b1, 1'b0,
                (n == 15) ? 4'b0010 : 4'b0000,
                (n == 5 || n == 10) ? 4'b0010 : 4'b0000);
      next_cycle();
    end
    drive(4'b0000, 1'b0, 1'b0);
    #2;
    check_bus("to_rel", 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    next_cycle();
    check_bus("to_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);

    // Async reset mid-BUSY (ptr=2 picks master 3), then re-arbitration from ptr=0 picks master 1.
    drive(4'b1010, 1'b0, 1'b0);
    #2;
    check_bus("ar_req", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    next_cycle();
    drive(4'b1010, 1'b1, 1'b0);
    #2;
    check_bus("ar_busy", 4'b1000, 1'b1, 1'b1, 1'b0, 4'b1000, 4'b0000);
    #1;
    i_reset_n = 1'b0;
    #1;
    check_bus("ar_rst", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    next_cycle();
    i_reset_n = 1'b1;
    drive(4'b1010, 1'b0, 1'b0);
    #2;
    check_bus("ar_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    next_cycle();
    check_bus("ar_regrant", 4'b0010, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    drive(4'b0000, 1'b0, 1'b0);
    next_cycle();
    check_bus("ar_end", 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
